// File: rtl/imm_alloc_if.sv
// imm_alloc_if: dispatch/issue/branch-resolution bundle for the immediate-entry allocator
interface imm_alloc_if #(
  parameter int ENT_SEL     = 4,
  parameter int SPECTAG_LEN = 5
);
  logic                   req_1;
  logic                   req_2;
  logic [SPECTAG_LEN-1:0] spectag_1;
  logic [SPECTAG_LEN-1:0] spectag_2;
  logic [ENT_SEL-1:0]     alloc_ptr_1;
  logic [ENT_SEL-1:0]     alloc_ptr_2;
  logic                   allocatable;
  logic                   issued_1;
  logic                   issued_2;
  logic [ENT_SEL-1:0]     issue_ptr_1;
  logic [ENT_SEL-1:0]     issue_ptr_2;
  logic                   prmiss;
  logic [SPECTAG_LEN-1:0] prmiss_mask;
  logic                   prsuccess;
  logic [SPECTAG_LEN-1:0] prsuccess_tag;
  logic [ENT_SEL:0]       free_count;
  modport master (
    output req_1, req_2, spectag_1, spectag_2, issued_1, issued_2, issue_ptr_1, issue_ptr_2,
           prmiss, prmiss_mask, prsuccess, prsuccess_tag,
    input  alloc_ptr_1, alloc_ptr_2, allocatable, free_count
  );
  modport slave (
    input  req_1, req_2, spectag_1, spectag_2, issued_1, issued_2, issue_ptr_1, issue_ptr_2,
           prmiss, prmiss_mask, prsuccess, prsuccess_tag,
    output alloc_ptr_1, alloc_ptr_2, allocatable, free_count
  );
endinterface

// File: rtl/imm_alloc.sv
// imm_alloc: two-slot immediate-buffer entry allocator with release, branch kill and tag retire
module imm_alloc #(
  parameter int ENT_NUM     = 16,
  parameter int ENT_SEL     = 4,
  parameter int SPECTAG_LEN = 5
) (
  input logic        clk,
  input logic        reset,
  imm_alloc_if.slave bus
);
  logic [ENT_NUM-1:0]     busy_q, busy_d;
  logic [SPECTAG_LEN-1:0] tag_q [ENT_NUM];
  logic [SPECTAG_LEN-1:0] tag_d [ENT_NUM];
  logic [ENT_SEL:0]       free_q, free_d, cnt;
  logic [ENT_SEL-1:0]     low_ptr, sec_ptr;
  logic                   low_found, sec_found;
  logic                   grant_1, grant_2;
  logic [SPECTAG_LEN-1:0] keep_mask;
  // lowest and second-lowest non-busy entries
  always_comb begin
    low_ptr   = '0;
    sec_ptr   = '0;
    low_found = 1'b0;
    sec_found = 1'b0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!busy_q[i] && !low_found) begin
        low_ptr   = ENT_SEL'(i);
        low_found = 1'b1;
      end else if (!busy_q[i] && !sec_found) begin
        sec_ptr   = ENT_SEL'(i);
        sec_found = 1'b1;
      end
    end
  end
  assign bus.alloc_ptr_1 = low_ptr;
  assign bus.alloc_ptr_2 = bus.req_1 ? sec_ptr : low_ptr;
  assign bus.allocatable = !bus.prmiss &&
                           (free_q >= (ENT_SEL+1)'(bus.req_1) + (ENT_SEL+1)'(bus.req_2));
  assign bus.free_count  = free_q;
  assign grant_1   = bus.allocatable & bus.req_1;
  assign grant_2   = bus.allocatable & bus.req_2;
  assign keep_mask = bus.prsuccess ? ~bus.prsuccess_tag : '1;
  // kill and release clears on pre-edge tags, then grants set (never overlapping: prmiss blocks grants)
  always_comb begin
    busy_d = busy_q;
    cnt    = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      tag_d[i] = tag_q[i] & keep_mask;
      if (bus.prmiss && |(tag_q[i] & bus.prmiss_mask)) busy_d[i] = 1'b0;
    end
    if (bus.issued_1) busy_d[bus.issue_ptr_1] = 1'b0;
    if (bus.issued_2) busy_d[bus.issue_ptr_2] = 1'b0;
    if (grant_1) begin
      busy_d[low_ptr] = 1'b1;
      tag_d[low_ptr]  = bus.spectag_1 & keep_mask;
    end
    if (grant_2) begin
      busy_d[bus.alloc_ptr_2] = 1'b1;
      tag_d[bus.alloc_ptr_2]  = bus.spectag_2 & keep_mask;
    end
    for (int i = 0; i < ENT_NUM; i++) cnt = cnt + (ENT_SEL+1)'(busy_d[i]);
    free_d = (ENT_SEL+1)'(ENT_NUM) - cnt;
  end
  // state registers; free count tracks busy population exactly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      free_q <= (ENT_SEL+1)'(ENT_NUM);
      tag_q  <= '{default: '0};
    end else begin
      busy_q <= busy_d;
      free_q <= free_d;
      tag_q  <= tag_d;
    end
  end
endmodule

// File: doc/imm_alloc.md
IMM_ALLOC -- requirements
Module: imm_alloc

Interface
REQ-001 SHALL have parameter ENT_NUM, default 16, number of immediate-buffer entries managed.
REQ-002 SHALL have parameter ENT_SEL, default 4, pointer width, log2(ENT_NUM).
REQ-003 SHALL have parameter SPECTAG_LEN, default 5, branch speculative-tag vector width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req_1, req_2  input  1 each  dispatch slot requests an immediate entry.
REQ-007 SHALL have ports spectag_1, spectag_2  input  SPECTAG_LEN each  speculative tag of each requesting instruction.
REQ-008 SHALL have ports alloc_ptr_1, alloc_ptr_2  output  ENT_SEL each  entry granted to slot 1 / slot 2.
REQ-009 SHALL have port allocatable  output  1  all asserted requests can be granted this cycle.
REQ-010 SHALL have ports issued_1, issued_2  input  1 each  issue-side release strobes.
REQ-011 SHALL have ports issue_ptr_1, issue_ptr_2  input  ENT_SEL each  entries to release.
REQ-012 SHALL have ports prmiss  input  1, prmiss_mask  input  SPECTAG_LEN  mispredict flush and kill mask.
REQ-013 SHALL have ports prsuccess  input  1, prsuccess_tag  input  SPECTAG_LEN  branch resolved correct; one-hot tag to retire.
REQ-014 SHALL have port free_count  output  ENT_SEL+1  number of non-busy entries.

Function
REQ-015 SHALL hold per entry a busy bit and a SPECTAG_LEN tag register.
REQ-016 SHALL drive alloc_ptr_1 combinationally as the lowest-index non-busy entry.
REQ-017 SHALL drive alloc_ptr_2 as the second-lowest non-busy entry when req_1=1, else the lowest non-busy entry.
REQ-018 SHALL drive allocatable = (free_count >= req_1 + req_2) and not prmiss.
REQ-019 SHALL commit an allocation only when allocatable=1: each granted entry set busy, tag loaded from its slot's spectag, at the rising edge; no partial grant.
REQ-020 SHALL, when allocatable=0, leave busy and tags unchanged by requests; requester holds req and retries.
REQ-021 SHALL clear busy of issue_ptr_n at the rising edge when issued_n=1; freed entry grantable from the next cycle only (no same-cycle reuse).
REQ-022 SHALL treat a release of a non-busy entry as a no-op and issued_1/issued_2 to the same pointer as a single release.
REQ-023 SHALL, on prmiss=1, clear busy of every entry whose (tag AND prmiss_mask) is non-zero, using pre-edge tag values; releases are still applied; no allocation commits.
REQ-024 SHALL, on prsuccess=1, clear bit prsuccess_tag in every entry's tag and in spectag_1/spectag_2 being loaded that edge.
REQ-025 SHALL apply simultaneous prmiss and prsuccess both, kill evaluated with pre-clear tags.
REQ-026 SHALL update free_count as a register: ENT_NUM minus busy population, exact after every edge, never exceeding ENT_NUM nor wrapping below 0.
REQ-027 SHALL order simultaneous events per edge: kill/release clears and allocation sets touch disjoint entries; a granted entry is never in the same edge's kill set.

Reset
REQ-028 SHALL, while reset=0, asynchronously clear all busy bits and tags and set free_count=ENT_NUM.
REQ-029 SHALL present after reset alloc_ptr_1=0, alloc_ptr_2=1 (req_1=1) or 0 (req_1=0), allocatable=1.
REQ-030 SHALL discard any request, release or flush coincident with reset assertion; operation resumes on first rising edge after reset=1.

Verification
REQ-031 Reset, req_1=req_2=1 for 8 cycles -> grants (0,1),(2,3)...(14,15); free_count 16->0; cycle 9 allocatable=0.
REQ-032 Full buffer, issued_1=1 issue_ptr_1=5 with req_1=1 -> allocatable=0 that cycle; next cycle alloc_ptr_1=5, allocatable=1.
REQ-033 One free entry (7), req_1=req_2=1 -> allocatable=0, no grant; req_2 alone -> alloc_ptr_2=7, granted.
REQ-034 Entries 0-3 tag 00001, 4-5 tag 00010; prmiss mask 00010 -> entries 4,5 freed, free_count +2, 0-3 busy.
REQ-035 prsuccess tag 00001 then prmiss mask 00001 -> no entry freed; issued_1=issued_2=1 both ptr 3 -> free_count +1 only.
